pushsw_mode_latch: RTL and testbench

PUSHSW_MODE_LATCH -- requirements
Module: pushsw_mode_latch

---
 rtl/pushsw_mode_latch.sv | 120 ++++++++++++
 tb/tb_pushsw_mode_latch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pushsw_mode_latch.sv
// Push-switch mode selector.
// Synchronizes and debounces six push switches. Each accepted press picks an
// ALU mode and captures the DIP operand value; every accepted press emits a
// one-cycle strobe.
module pushsw_mode_latch #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] PUSHSW_input,
  input  logic [9:0] DIP_input,
  output logic [2:0] mode,
  output logic [9:0] operands,
  output logic       mode_strobe
);

  // Last counter value before a level change is accepted.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [5:0] push_meta_q, push_sync_q;
  logic [9:0] dip_meta_q, dip_sync_q;
  logic [5:0] deb_vec;
  logic [5:0] deb_prev_q;
  logic [5:0] rise;

  logic [2:0] mode_q, mode_d;
  logic [9:0] operands_q, operands_d;
  logic       strobe_q, strobe_d;

  // Two-flop synchronizers for the raw push switches and the DIP bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_meta_q <= '0;
      push_sync_q <= '0;
      dip_meta_q  <= '0;
      dip_sync_q  <= '0;
    end else begin
      push_meta_q <= PUSHSW_input;
      push_sync_q <= push_meta_q;
      dip_meta_q  <= DIP_input;
      dip_sync_q  <= dip_meta_q;
    end
  end

  // One independent debouncer per push switch.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_deb
      logic [15:0] cnt_q, cnt_d;
      logic        deb_q, deb_d;

      // Count consecutive cycles that disagree with the accepted level;
      // the count restarts whenever the input agrees again.
      always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (push_sync_q[gi] == deb_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          deb_d = push_sync_q[gi];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Debounce counter and accepted level registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign deb_vec[gi] = deb_q;
    end
  endgenerate

  // A press event is a 0->1 transition of the debounced level.
  assign rise = deb_vec & ~deb_prev_q;

  // Lowest-numbered rising switch wins; others in the same cycle are dropped.
  always_comb begin
    mode_d     = mode_q;
    operands_d = operands_q;
    strobe_d   = 1'b0;
    if (rise != 6'd0) begin
      strobe_d   = 1'b1;
      operands_d = dip_sync_q;
      if (rise[0])      mode_d = 3'd0;
      else if (rise[1]) mode_d = 3'd1;
      else if (rise[2]) mode_d = 3'd2;
      else if (rise[3]) mode_d = 3'd3;
      else if (rise[4]) mode_d = 3'd4;
      else              mode_d = (mode_q >= 3'd6) ? 3'd0 : mode_q + 3'd1;
    end
  end

  // Edge-detect history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_prev_q <= '0;
      mode_q     <= '0;
      operands_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      deb_prev_q <= deb_vec;
      mode_q     <= mode_d;
      operands_q <= operands_d;
      strobe_q   <= strobe_d;
    end
  end

  assign mode        = mode_q;
  assign operands    = operands_q;
  assign mode_strobe = strobe_q;

endmodule

// File: tb/tb_pushsw_mode_latch.sv
// Bench for pushsw_mode_latch with a 4-cycle debounce window.
// A behavioural model tracks the expected outputs on every clock; directed
// scenarios and a randomized phase drive the switches.
module tb_pushsw_mode_latch;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] pushsw;
  logic [9:0] dip;
  logic [2:0] mode;
  logic [9:0] operands;
  logic       mode_strobe;

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;

  // Model state: raw samples from the previous two edges, last DC
  // synchronized samples per switch, accepted levels and outputs.
  logic [5:0]    m_p1, m_p2;
  logic [9:0]    m_d1, m_d2;
  logic [DC-1:0] m_win [6];
  logic [5:0]    m_deb, m_deb_prev;
  logic [2:0]    m_mode;
  logic [9:0]    m_ops;
  logic          m_strobe;

  pushsw_mode_latch #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .PUSHSW_input (pushsw),
    .DIP_input    (dip),
    .mode         (mode),
    .operands     (operands),
    .mode_strobe  (mode_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_d1 = '0; m_d2 = '0;
    for (int i = 0; i < 6; i++) m_win[i] = '0;
    m_deb = '0; m_deb_prev = '0;
    m_mode = '0; m_ops = '0; m_strobe = 1'b0;
  endtask

  // One clock edge of the specified behaviour: a level is accepted once the
  // synchronized input has disagreed with it for DC consecutive samples.
  task automatic model_step();
    logic [5:0] s;
    logic [5:0] rise;
    int         j;
    s    = m_p2;
    rise = m_deb & ~m_deb_prev;
    if (rise != 6'd0) begin
      j = 0;
      for (int i = 5; i >= 0; i--) if (rise[i]) j = i;
      m_strobe = 1'b1;
      m_ops    = m_d2;
      if (j < 5) m_mode = 3'(j);
      else       m_mode = 3'((int'(m_mode) + 1) % 7);
    end else begin
      m_strobe = 1'b0;
    end
    m_deb_prev = m_deb;
    for (int i = 0; i < 6; i++) begin
      m_win[i] = {m_win[i][DC-2:0], s[i]};
      if (m_win[i] == {DC{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
    end
    m_p2 = m_p1; m_p1 = pushsw;
    m_d2 = m_d1; m_d1 = dip;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check("mode", 32'(mode), 32'(m_mode));
    check("operands", 32'(operands), 32'(m_ops));
    check("strobe", 32'(mode_strobe), 32'(m_strobe));
    if (mode_strobe) strobe_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  task automatic press_release(input int sw);
    pushsw[sw] = 1'b1;
    ticks(10);
    pushsw[sw] = 1'b0;
    ticks(10);
  endtask

  initial begin
    int first;
    int hold;
    rst = 1'b1; pushsw = '0; dip = '0;
    model_reset();
    ticks(3);
    rst = 1'b0;
    ticks(3);
    $display("reset: mode=%0d operands=%0h strobe=%0b", mode, operands, mode_strobe);

    // Clean press of SW3 with a known DIP value.
    dip = 10'h2A5; pushsw = 6'b001000; strobe_cnt = 0; first = 0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (mode_strobe && first == 0) first = t;
    end
    check("sw3_latency", 32'(first), 32'd7);
    check("sw3_strobes", 32'(strobe_cnt), 32'd1);
    check("sw3_mode", 32'(mode), 32'd3);
    check("sw3_operands", 32'(operands), 32'h2A5);
    pushsw = '0; ticks(10);
    $display("sw3 press: latency=%0d mode=%0d operands=%0h", first, mode, operands);

    // Short SW0 glitches must be ignored, then a steady press accepted.
    strobe_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      pushsw[0] = 1'b1; ticks(2);
      pushsw[0] = 1'b0; ticks(2);
    end
    check("glitch_strobes", 32'(strobe_cnt), 32'd0);
    check("glitch_mode", 32'(mode), 32'd3);
    pushsw[0] = 1'b1; ticks(12);
    check("sw0_strobes", 32'(strobe_cnt), 32'd1);
    check("sw0_mode", 32'(mode), 32'd0);
    pushsw = '0; ticks(10);
    $display("sw0 glitch+press: strobes=%0d mode=%0d", strobe_cnt, mode);

    // SW5 increment with wrap from 6 to 0.
    press_release(4);
    press_release(5);
    check("mode_five", 32'(mode), 32'd5);
    strobe_cnt = 0;
    press_release(5); check("inc_to_6", 32'(mode), 32'd6);
    press_release(5); check("wrap_to_0", 32'(mode), 32'd0);
    press_release(5); check("inc_to_1", 32'(mode), 32'd1);
    check("inc_strobes", 32'(strobe_cnt), 32'd3);
    $display("sw5 increments: strobes=%0d mode=%0d", strobe_cnt, mode);

    // Simultaneous SW1/SW4: lowest wins; SW4 re-press while SW1 held.
    press_release(3);
    strobe_cnt = 0;
    pushsw = 6'b010010; ticks(10);
    check("simul_strobes", 32'(strobe_cnt), 32'd1);
    check("simul_mode", 32'(mode), 32'd1);
    pushsw = 6'b000010; ticks(10);
    pushsw = 6'b010010; ticks(10);
    check("sw4_repress_mode", 32'(mode), 32'd4);
    check("sw4_repress_strobes", 32'(strobe_cnt), 32'd2);
    pushsw = '0; ticks(10);
    $display("simultaneous press: mode=%0d strobes=%0d", mode, strobe_cnt);

    // DIP changes alone do not disturb operands; a long hold strobes once.
    dip = 10'h155; strobe_cnt = 0; ticks(10);
    check("dip_hold_operands", 32'(operands), 32'h2A5);
    check("dip_hold_strobes", 32'(strobe_cnt), 32'd0);
    pushsw = 6'b000100; ticks(100);
    check("hold_strobes", 32'(strobe_cnt), 32'd1);
    check("hold_mode", 32'(mode), 32'd2);
    check("hold_operands", 32'(operands), 32'h155);
    pushsw = '0; ticks(10);
    $display("dip change and long hold: strobes=%0d operands=%0h", strobe_cnt, operands);

    // Reset in the middle of a SW2 debounce, switch kept held across it.
    pushsw = 6'b000100; ticks(4);
    rst = 1'b1; model_reset();
    #1;
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_operands", 32'(operands), 32'd0);
    check("async_rst_strobe", 32'(mode_strobe), 32'd0);
    ticks(3);
    rst = 1'b0; strobe_cnt = 0; first = 0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (mode_strobe && first == 0) first = t;
    end
    check("post_rst_latency", 32'(first), 32'd7);
    check("post_rst_strobes", 32'(strobe_cnt), 32'd1);
    check("post_rst_mode", 32'(mode), 32'd2);
    pushsw = '0; ticks(10);
    $display("reset mid-debounce: latency=%0d mode=%0d", first, mode);

    // Randomized switch/DIP activity against the model.
    strobe_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      pushsw = pushsw ^ (6'($urandom) & 6'($urandom));
      dip    = 10'($urandom);
      hold   = $urandom_range(1, 9);
      if (n == 100) begin
        rst = 1'b1; model_reset();
        ticks(2);
        rst = 1'b0;
      end
      ticks(hold);
    end
    $display("random phase: strobes=%0d final mode=%0d", strobe_cnt, mode);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
